gpr: RTL and testbench



---
 rtl/gpr.sv | 59 +++++
 tb/tb_gpr.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/gpr.sv
// General-purpose register: WIDTH bit slices, each a D flip-flop with async
// clear, a load/hold mux and an AND gate that zeroes the bus when disabled.

module gpr_slice (
    input  logic clk,
    input  logic reset,
    input  logic load_en,
    input  logic out_en,
    input  logic d_in,
    output logic q_out
);

    logic bit_q;
    logic bit_d;

    // Load/hold mux in front of the flop
    always_comb begin
        bit_d = bit_q;
        if (load_en) begin
            bit_d = d_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    // Zero when disabled so several registers can be OR-combined onto one bus
    assign q_out = bit_q & out_en;

endmodule

module gpr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic             out_en,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_slice
        gpr_slice u_slice (
            .clk     (clk),
            .reset   (reset),
            .load_en (load_en),
            .out_en  (out_en),
            .d_in    (bus_in[i]),
            .q_out   (bus_out[i])
        );
    end

endmodule

// File: tb/tb_gpr.sv
// Directed bench for gpr (WIDTH=8) with hand-computed expected bus values.

module tb_gpr;

    logic       clk;
    logic       reset;
    logic       load_en;
    logic       out_en;
    logic [7:0] bus_in;
    logic [7:0] bus_out;

    int unsigned n_tests;
    int unsigned n_fail;

    gpr #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .load_en (load_en),
        .out_en  (out_en),
        .bus_in  (bus_in),
        .bus_out (bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    // Advance to just after the next falling edge (mid-cycle, away from capture)
    task automatic after_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        load_en = 1'b1;
        out_en  = 1'b1;
        bus_in  = 8'h55;

        // Reset wins over a pending load
        after_pos();
        check("rst_load_ignored", bus_out, 8'h00);
        after_neg();
        reset   = 1'b0;
        load_en = 1'b0;
        #1 check("post_rst", bus_out, 8'h00);
        for (int i = 0; i < 2; i++) begin
            after_pos();
            check("post_rst_hold", bus_out, 8'h00);
        end

        // Load A5 hidden, then FF ignored while load_en=0
        after_neg();
        bus_in  = 8'hA5;
        load_en = 1'b1;
        out_en  = 1'b0;
        after_pos();
        check("load_a5_hidden", bus_out, 8'h00);
        after_neg();
        bus_in  = 8'hFF;
        load_en = 1'b0;
        after_pos();
        check("ff_hidden", bus_out, 8'h00);
        after_neg();
        out_en = 1'b1;
        #1 check("show_a5", bus_out, 8'hA5);

        // Load while visible: old value until the edge, new after
        bus_in  = 8'h3C;
        load_en = 1'b1;
        #1 check("before_edge_a5", bus_out, 8'hA5);
        after_pos();
        check("after_edge_3c", bus_out, 8'h3C);
        after_neg();
        load_en = 1'b0;
        out_en  = 1'b0;
        #1 check("disable_3c", bus_out, 8'h00);

        // Hidden load of 12
        bus_in  = 8'h12;
        load_en = 1'b1;
        after_pos();
        check("load_12_hidden", bus_out, 8'h00);
        after_neg();
        load_en = 1'b0;
        out_en  = 1'b1;
        #1 check("show_12", bus_out, 8'h12);

        // Async reset between edges, load of 77 blocked
        #1 reset = 1'b1;
        #1 check("async_rst", bus_out, 8'h00);
        load_en = 1'b1;
        bus_in  = 8'h77;
        after_pos();
        check("rst_blocks_77", bus_out, 8'h00);
        after_neg();
        reset   = 1'b0;
        load_en = 1'b0;
        #1 check("q_zero_after_rst", bus_out, 8'h00);

        // First load after reset works
        bus_in  = 8'hC3;
        load_en = 1'b1;
        after_pos();
        check("first_load_c3", bus_out, 8'hC3);
        after_neg();
        load_en = 1'b0;

        // Random bus_in with load disabled never reaches Q
        for (int i = 0; i < 8; i++) begin
            bus_in = 8'($urandom_range(0, 255));
            after_pos();
            check("hold_c3", bus_out, 8'hC3);
            #2;
        end

        // out_en toggled every half-cycle, independent of the clock
        for (int i = 0; i < 8; i++) begin
            @(posedge clk or negedge clk);
            #2 out_en = ~out_en;
            #1 check("oe_toggle", bus_out, out_en ? 8'hC3 : 8'h00);
        end
        after_neg();
        out_en = 1'b1;
        #1 check("oe_kept_q", bus_out, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
